// File: rtl/stage3_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU opcodes and
// the set of ALU ops that update the architectural zero/neg flags.
package stage3_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 6;

  typedef enum logic [2:0] {
    ALUOP_ADD    = 3'b000,
    ALUOP_SUB    = 3'b001,
    ALUOP_NEG    = 3'b010,
    ALUOP_PASS_A = 3'b011,
    ALUOP_PASS_B = 3'b100,
    ALUOP_SVPC   = 3'b101
  } aluop_e;

  function automatic logic is_flag_op(input logic [2:0] op);
    return (op == ALUOP_ADD) || (op == ALUOP_SUB) || (op == ALUOP_NEG);
  endfunction

endpackage

// File: rtl/stage3_if.sv
// ID/EX in, EX/MEM out and flag bundle of the execute stage.
// master = pipeline/decode side, slave = the execute stage itself.
interface stage3_if;
  import stage3_pkg::*;

  logic [DATA_W-1:0] in_imm;
  logic [REG_W-1:0]  in_rd;
  logic [DATA_W-1:0] in_rd1;
  logic [DATA_W-1:0] in_rd2;
  logic [DATA_W-1:0] in_PC;
  logic              in_brz, in_brn, in_j;
  logic              in_regw, in_wai, in_memw, in_memr;
  logic              in_alusrc;
  logic [2:0]        in_aluop;

  logic              zero, neg;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_store;
  logic [REG_W-1:0]  out_rd;
  logic              out_regw, out_wai, out_memw, out_memr;
  logic              out_taken;
  logic [DATA_W-1:0] out_target;
  logic              flush;

  modport master (
    output in_imm, in_rd, in_rd1, in_rd2, in_PC, in_brz, in_brn, in_j,
           in_regw, in_wai, in_memw, in_memr, in_alusrc, in_aluop,
    input  zero, neg, out_result, out_store, out_rd, out_regw, out_wai,
           out_memw, out_memr, out_taken, out_target, flush
  );

  modport slave (
    input  in_imm, in_rd, in_rd1, in_rd2, in_PC, in_brz, in_brn, in_j,
           in_regw, in_wai, in_memw, in_memr, in_alusrc, in_aluop,
    output zero, neg, out_result, out_store, out_rd, out_regw, out_wai,
           out_memw, out_memr, out_taken, out_target, flush
  );

endinterface

// File: rtl/stage3_alu.sv
// Combinational ALU of the execute stage; result only, no carry/overflow kept.
module stage3_alu
  import stage3_pkg::*;
(
  input  logic [2:0]        aluop,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (aluop)
      ALUOP_ADD:    result = a + b;
      ALUOP_SUB:    result = a - b;
      ALUOP_NEG:    result = '0 - a;
      ALUOP_PASS_A: result = a;
      ALUOP_PASS_B: result = b;
      ALUOP_SVPC:   result = pc + b;
      default:      result = '0;
    endcase
  end

endmodule

// File: rtl/stage3.sv
// Execute stage: ALU, zero/neg flags, branch resolution, wrong-path squash and
// EX/MEM register. Define STAGE3_PERF_EN to add saturating perf counters.
module stage3 #(
  parameter int DATA_W        = stage3_pkg::DATA_W,
  parameter int REG_W         = stage3_pkg::REG_W,
  parameter int BRANCH_SHADOW = 2
) (
  input  logic        clk,
  input  logic        rst,
  stage3_if.slave     bus
`ifdef STAGE3_PERF_EN
  ,
  output logic [31:0] perf_exec,
  output logic [31:0] perf_taken,
  output logic [31:0] perf_squash
`endif
);
  import stage3_pkg::*;

  localparam int SQ_W = $clog2(BRANCH_SHADOW + 1);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] alu_res;
  logic [REG_W-1:0]  rd_q;
  logic [SQ_W-1:0]   sq_cnt;
  logic              squashed;
  logic              take;
  logic              flag_upd;

  assign b_op = bus.in_alusrc ? bus.in_imm : bus.in_rd2;

  stage3_alu u_alu (
    .aluop  (bus.in_aluop),
    .a      (bus.in_rd1),
    .b      (b_op),
    .pc     (bus.in_PC),
    .result (alu_res)
  );

  // Branch decision reads the flag register before this edge's update.
  always_comb begin
    squashed = (sq_cnt != '0);
    take     = !squashed && (bus.in_j || (bus.in_brz && bus.zero) ||
                             (bus.in_brn && bus.neg));
    flag_upd = !squashed && bus.in_regw && is_flag_op(bus.in_aluop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.zero       <= 1'b0;
      bus.neg        <= 1'b0;
      bus.out_result <= '0;
      bus.out_store  <= '0;
      rd_q           <= '0;
      bus.out_regw   <= 1'b0;
      bus.out_wai    <= 1'b0;
      bus.out_memw   <= 1'b0;
      bus.out_memr   <= 1'b0;
      bus.out_taken  <= 1'b0;
      bus.out_target <= '0;
      sq_cnt         <= '0;
    end else begin
      if (flag_upd) begin
        bus.zero <= (alu_res == '0);
        bus.neg  <= alu_res[DATA_W-1];
      end
      bus.out_result <= alu_res;
      bus.out_store  <= bus.in_rd2;
      rd_q           <= bus.in_rd;
      bus.out_regw   <= bus.in_regw && !squashed;
      bus.out_wai    <= bus.in_wai;
      bus.out_memw   <= bus.in_memw && !squashed;
      bus.out_memr   <= bus.in_memr && !squashed;
      bus.out_taken  <= take;
      bus.out_target <= take ? bus.in_rd1 : '0;
      if (take)
        sq_cnt <= SQ_W'(BRANCH_SHADOW);
      else if (squashed)
        sq_cnt <= sq_cnt - SQ_W'(1);
    end
  end

  assign bus.out_rd = rd_q;
  assign bus.flush  = bus.out_taken;

`ifdef STAGE3_PERF_EN
  logic active;
  assign active = bus.in_regw || bus.in_memw || bus.in_memr ||
                  bus.in_j || bus.in_brz || bus.in_brn;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_exec   <= '0;
      perf_taken  <= '0;
      perf_squash <= '0;
    end else begin
      if (!squashed && active && perf_exec != '1)
        perf_exec <= perf_exec + 32'd1;
      if (take && perf_taken != '1)
        perf_taken <= perf_taken + 32'd1;
      if (squashed && perf_squash != '1)
        perf_squash <= perf_squash + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage3.sv
// Vector-table bench for stage3 (BRANCH_SHADOW=2); expectations go through a
// scoreboard queue and are compared one cycle after each vector is driven.
module tb_stage3;
  import stage3_pkg::*;

  localparam logic [6:0] C_REGW = 7'h40, C_MEMW = 7'h20, C_MEMR = 7'h10,
                         C_WAI  = 7'h08, C_BRZ  = 7'h04, C_BRN  = 7'h02,
                         C_J    = 7'h01;
  localparam logic [3:0] E_REGW = 4'h8, E_MEMW = 4'h4, E_MEMR = 4'h2,
                         E_TAKEN = 4'h1;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, pc;
    logic        alusrc;
    logic [5:0]  rd;
    logic [6:0]  ctl;
    logic [31:0] e_result;
    logic [3:0]  e_ctl;
    logic [31:0] e_target;
    logic        e_zero, e_neg;
  } vec_t;

  typedef struct {
    logic [31:0] result, store, target;
    logic [5:0]  rd;
    logic        regw, wai, memw, memr, taken, zero, neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage3_if bus ();

`ifdef STAGE3_PERF_EN
  logic [31:0] perf_exec, perf_taken, perf_squash;
  stage3 #(.BRANCH_SHADOW(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_exec(perf_exec), .perf_taken(perf_taken), .perf_squash(perf_squash)
  );
`else
  stage3 #(.BRANCH_SHADOW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  vec_t vq[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   perf_idx = -1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic add(input logic [2:0] op, input logic [31:0] rd1, rd2, imm,
                     input logic alusrc, input logic [31:0] pc,
                     input logic [5:0] rd, input logic [6:0] ctl,
                     input logic [31:0] e_result, input logic [3:0] e_ctl,
                     input logic [31:0] e_target, input logic e_zero, e_neg);
    vec_t v;
    v.rst = 1'b0; v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.alusrc = alusrc; v.pc = pc; v.rd = rd; v.ctl = ctl;
    v.e_result = e_result; v.e_ctl = e_ctl; v.e_target = e_target;
    v.e_zero = e_zero; v.e_neg = e_neg;
    vq.push_back(v);
  endtask

  // Reset vector with random inputs: every output must read back 0.
  task automatic add_rst();
    vec_t v;
    v.rst = 1'b1; v.op = 3'($urandom); v.rd1 = $urandom; v.rd2 = $urandom;
    v.imm = $urandom; v.alusrc = 1'($urandom); v.pc = $urandom;
    v.rd = 6'($urandom); v.ctl = 7'($urandom);
    v.e_result = '0; v.e_ctl = '0; v.e_target = '0; v.e_zero = 1'b0; v.e_neg = 1'b0;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    string n;
    @(negedge clk);
    rst           = v.rst;
    bus.in_aluop  = v.op;
    bus.in_rd1    = v.rd1;
    bus.in_rd2    = v.rd2;
    bus.in_imm    = v.imm;
    bus.in_alusrc = v.alusrc;
    bus.in_PC     = v.pc;
    bus.in_rd     = v.rd;
    {bus.in_regw, bus.in_memw, bus.in_memr, bus.in_wai,
     bus.in_brz, bus.in_brn, bus.in_j} = v.ctl;
    e.result = v.e_result;
    e.target = v.e_target;
    e.store  = v.rst ? 32'h0 : v.rd2;
    e.rd     = v.rst ? 6'h0 : v.rd;
    e.wai    = v.rst ? 1'b0 : v.ctl[3];
    {e.regw, e.memw, e.memr, e.taken} = v.e_ctl;
    e.zero = v.e_zero;
    e.neg  = v.e_neg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n = $sformatf("v%0d", idx);
    check({n, " result"}, bus.out_result, e.result);
    check({n, " store"},  bus.out_store,  e.store);
    check({n, " rd"},     32'(bus.out_rd), 32'(e.rd));
    check({n, " ctl"},    32'({bus.out_regw, bus.out_memw, bus.out_memr, bus.out_wai}),
                          32'({e.regw, e.memw, e.memr, e.wai}));
    check({n, " taken"},  32'({bus.out_taken, bus.flush}), 32'({e.taken, e.taken}));
    check({n, " target"}, bus.out_target, e.target);
    check({n, " flags"},  32'({bus.zero, bus.neg}), 32'({e.zero, e.neg}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_imm = '0; bus.in_rd = '0; bus.in_rd1 = '0; bus.in_rd2 = '0;
    bus.in_PC = '0; bus.in_brz = 0; bus.in_brn = 0; bus.in_j = 0;
    bus.in_regw = 0; bus.in_wai = 0; bus.in_memw = 0; bus.in_memr = 0;
    bus.in_alusrc = 0; bus.in_aluop = '0;

    //  op            rd1      rd2     imm   src pc     rd  ctl                       result        e_ctl              target   z  n
    add_rst();
    add_rst();
    add(ALUOP_ADD,    5,       7,      0,    0,  0,     3,  C_REGW,                   32'd12,       E_REGW,            0,       0, 0);
    add_rst();
    add(ALUOP_SUB,    5,       5,      0,    0,  0,     4,  C_REGW,                   32'd0,        E_REGW,            0,       1, 0);
    add(ALUOP_PASS_A, 32'h40,  0,      0,    0,  0,     0,  C_BRZ,                    32'h40,       E_TAKEN,           32'h40,  1, 0);
    add(ALUOP_ADD,    1,       2,      0,    0,  0,     5,  C_REGW|C_MEMW|C_BRZ,      32'd3,        4'h0,              0,       1, 0);
    add(ALUOP_SUB,    3,       1,      0,    0,  0,     6,  C_REGW|C_MEMW|C_MEMR|C_WAI, 32'd2,      4'h0,              0,       1, 0);
    add(ALUOP_ADD,    0,       0,      0,    0,  0,     7,  C_REGW|C_MEMW,            32'd0,        E_REGW|E_MEMW,     0,       1, 0);
    perf_idx = vq.size() - 1;
    add(ALUOP_NEG,    1,       0,      0,    0,  0,     8,  C_REGW,                   32'hFFFFFFFF, E_REGW,            0,       0, 1);
    add(ALUOP_ADD,    1,       1,      0,    0,  0,     8,  C_REGW,                   32'd2,        E_REGW,            0,       0, 0);
    add(ALUOP_ADD,    32'h80,  0,      0,    0,  0,     0,  C_BRN,                    32'h80,       4'h0,              0,       0, 0);
    add(ALUOP_SVPC,   0,       32'h99, 4,    1,  32'h10, 9, C_REGW,                   32'h14,       E_REGW,            0,       0, 0);
    add(ALUOP_PASS_B, 0,       32'h77, 32'h1234, 1, 0,  10, C_MEMR,                   32'h1234,     E_MEMR,            0,       0, 0);
    add(ALUOP_SUB,    3,       5,      0,    0,  0,     11, 7'h00,                    32'hFFFFFFFE, 4'h0,              0,       0, 0);
    add(ALUOP_SUB,    3,       5,      0,    0,  0,     11, C_REGW,                   32'hFFFFFFFE, E_REGW,            0,       0, 1);
    add(3'b110,       32'h100, 0,      0,    0,  0,     12, C_REGW|C_BRN,             32'd0,        E_REGW|E_TAKEN,    32'h100, 0, 1);
    add(ALUOP_PASS_B, 32'h200, 0,      32'h55, 1, 0,    12, C_REGW|C_J,               32'h55,       4'h0,              0,       0, 1);
    add(3'b111,       0,       0,      0,    0,  0,     13, C_MEMR,                   32'd0,        4'h0,              0,       0, 1);
    add(ALUOP_ADD,    32'h300, 0,      0,    0,  0,     14, C_J,                      32'h300,      E_TAKEN,           32'h300, 0, 1);
    add(ALUOP_ADD,    1,       1,      0,    0,  0,     14, C_REGW,                   32'd2,        4'h0,              0,       0, 1);
    add(ALUOP_NEG,    5,       0,      0,    0,  0,     14, C_REGW|C_MEMW,            32'hFFFFFFFB, 4'h0,              0,       0, 1);
    add(ALUOP_PASS_B, 0,       9,      0,    0,  0,     15, C_REGW,                   32'd9,        E_REGW,            0,       0, 1);
    add(ALUOP_PASS_A, 32'h40,  0,      0,    0,  0,     0,  C_J,                      32'h40,       E_TAKEN,           32'h40,  0, 1);
    add_rst();
    add(ALUOP_ADD,    2,       2,      0,    0,  0,     16, C_REGW,                   32'd4,        E_REGW,            0,       0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], i);
`ifdef STAGE3_PERF_EN
      if (i == perf_idx) begin
        check("perf_exec",   perf_exec,   32'd3);
        check("perf_taken",  perf_taken,  32'd1);
        check("perf_squash", perf_squash, 32'd2);
      end
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
